alu_sequencer: RTL and testbench
================================

# alu_sequencer

Command-side driver for the switch/button ALU. It accepts one {A, B, opcode} command over a valid/ready handshake and replays it as the three-step load sequence: switches plus boton1, then switches plus boton2, then switches plus boton3. It then waits for the ALU to settle, captures o_ALUout/o_carry and returns them over a valid/ready result handshake. It replaces manual switch/button entry when the ALU is driven from a host or UART front end.

## Interface
- BUS_SIZE, 8, data/switch width
- OP_SIZE, 6, opcode width; zero-extended onto switches
- PULSE_CYCLES, 2, button high time in clocks (≥1)
- SETTLE_CYCLES, 2, clocks between opcode-phase end and capture (≥1)

Ports:
- i_clock  in  1  system clock, rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_cmd_valid  in  1  command valid
- o_cmd_ready  out  1  high only in IDLE
- i_cmd_a  in  BUS_SIZE  operand A
- i_cmd_b  in  BUS_SIZE  operand B
- i_cmd_op  in  OP_SIZE  opcode
- o_swiches  out  BUS_SIZE  to ALU i_swiches
- o_boton1 / o_boton2 / o_boton3  out  1 each  to ALU load strobes
- i_ALUout  in  BUS_SIZE  from ALU o_ALUout
- i_carry  in  1  from ALU o_carry
- o_result_valid  out  1  result available
- i_result_ready  in  1  result consumed
- o_result  out  BUS_SIZE  captured ALU result
- o_result_carry  out  1  captured carry
- o_illegal  out  1  command opcode not in legal set

## Operation
- A command is accepted on a rising edge with i_cmd_valid & o_cmd_ready. A, B and op are registered at that edge. Inputs are ignored while busy.
- Legal opcodes: ADD 100000, SUB 100010, AND 100100, OR 100101, XOR 100110, NOR 100111, SRL 000010, SRA 000011.
- States: IDLE, SETUP_x, PULSE_x, HOLD_x (x = A, B, OP), SETTLE, DONE.
- Each phase behaves as follows:
  - SETUP: 1 cycle; switches driven, button low.
  - PULSE: PULSE_CYCLES cycles; matching button high.
  - HOLD: 1 cycle; button low, switches held.
- Phase order is A→boton1, B→boton2, OP→boton3. o_swiches carries {0…, op} in the OP phase.
- SETTLE counts SETTLE_CYCLES. On its last edge, i_ALUout and i_carry are registered into o_result and o_result_carry, and the FSM enters DONE.
- DONE: o_result_valid = 1. On an edge with i_result_ready the FSM returns to IDLE and o_result_valid drops.
- Illegal opcode: the command is still accepted. No switch/button activity occurs; the FSM goes IDLE→DONE directly with o_result = 0, o_result_carry = 0, o_illegal = 1. o_illegal is cleared on the next accept.
- Buttons are one-hot or all-zero at all times. o_swiches = 0 in IDLE, SETTLE and DONE.

## Timing
- Reset (async, immediate): state IDLE, o_cmd_ready = 1, all buttons 0, o_swiches 0, o_result_valid 0, o_result 0, o_result_carry 0, o_illegal 0. Counters clear.
- Latency for a legal command accepted at edge k:
  - SETUP_A occupies cycle k+1.
  - Each phase is PULSE_CYCLES+2 cycles.
  - o_result_valid rises after edge k + 3·(PULSE_CYCLES+2) + SETTLE_CYCLES. With defaults that is edge k+14, visible in cycle k+15.
- Illegal command: o_result_valid is high in cycle k+1.
- o_cmd_ready is low from the cycle after acceptance until the cycle after the result is consumed. There is no command/result overlap, so at most one command is in flight.
- Result backpressure: o_result, o_result_carry and o_illegal stay stable while o_result_valid & !i_result_ready.
- Reset asserted mid-PULSE: buttons drop asynchronously and the command is discarded. There is no partial result.
- Counters are sized clog2(max(PULSE_CYCLES, SETTLE_CYCLES)+1) and wrap is never reached; each counter reloads on state entry.

## Structure
- Shared package alu_pkg holds:
  - the BUS_SIZE and OP_SIZE defaults
  - the eight opcode localparams
  - an is_legal_op function
- The state enum is local to the module.
- One sub-module, alu_strobe, drives a single phase (SETUP/PULSE/HOLD counter with start/done). It is instantiated once and retargeted by phase select; the button demux sits in the parent.

## Test plan
Bench: alu_sequencer driving the real alu (8-bit) with defaults.
- ADD A=255, B=2 → o_result 0x01, o_result_carry 1; o_result_valid in cycle k+15; boton1/2/3 each high exactly 2 cycles, never overlapping.
- SUB A=10, B=4 → o_result 6, carry per ALU; o_cmd_ready low throughout; a second i_cmd_valid pulse mid-sequence is ignored.
- AND A=0x37, B=0x65 → o_result 0x25; o_swiches shows 0x37, 0x65, 0x24 in the respective phases.
- Illegal op 111111 → o_illegal 1, o_result 0, o_result_valid in cycle k+1, no button ever high; the next legal command clears o_illegal.
- Backpressure: hold i_result_ready low 10 cycles after an OR 0xF0|0x0F → o_result 0xFF stable, o_cmd_ready low; release → IDLE next cycle.
- Reset during PULSE_B → all buttons and o_swiches 0 immediately, o_cmd_ready 1, o_result_valid 0; a fresh XOR 0xAA^0xFF returns 0x55.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: default widths,
// the legal opcode set and an opcode legality check.
package alu_pkg;

    localparam int DEF_BUS_SIZE = 8;
    localparam int DEF_OP_SIZE  = 6;

    localparam logic [DEF_OP_SIZE-1:0] OP_ADD = 6'b100000;
    localparam logic [DEF_OP_SIZE-1:0] OP_SUB = 6'b100010;
    localparam logic [DEF_OP_SIZE-1:0] OP_AND = 6'b100100;
    localparam logic [DEF_OP_SIZE-1:0] OP_OR  = 6'b100101;
    localparam logic [DEF_OP_SIZE-1:0] OP_XOR = 6'b100110;
    localparam logic [DEF_OP_SIZE-1:0] OP_NOR = 6'b100111;
    localparam logic [DEF_OP_SIZE-1:0] OP_SRL = 6'b000010;
    localparam logic [DEF_OP_SIZE-1:0] OP_SRA = 6'b000011;

    // True when the opcode is one the ALU implements.
    function automatic logic is_legal_op(input logic [DEF_OP_SIZE-1:0] op);
        logic legal;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRL, OP_SRA: legal = 1'b1;
            default:                        legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/alu_strobe.sv
// Timing engine for one load phase: SETUP (1 cycle), PULSE (PULSE_CYCLES
// cycles), HOLD (1 cycle). A start in IDLE or HOLD begins a new phase, so
// the three phases run back to back. The parent decides which button the
// pulse belongs to.
module alu_strobe
    import alu_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int CNT_W        = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic pulse_last,
    output logic done
);

    localparam logic [1:0] STEP_IDLE  = 2'd0;
    localparam logic [1:0] STEP_SETUP = 2'd1;
    localparam logic [1:0] STEP_PULSE = 2'd2;
    localparam logic [1:0] STEP_HOLD  = 2'd3;

    logic [1:0]       step_r;
    logic [CNT_W-1:0] cnt_r;

    // Phase step sequencing; the pulse counter reloads on PULSE entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_r <= STEP_IDLE;
            cnt_r  <= {CNT_W{1'b0}};
        end else begin
            case (step_r)
                STEP_IDLE: begin
                    if (start) begin
                        step_r <= STEP_SETUP;
                    end
                end
                STEP_SETUP: begin
                    step_r <= STEP_PULSE;
                    cnt_r  <= CNT_W'(PULSE_CYCLES - 1);
                end
                STEP_PULSE: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        step_r <= STEP_HOLD;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                STEP_HOLD: begin
                    step_r <= start ? STEP_SETUP : STEP_IDLE;
                end
                default: begin
                    step_r <= STEP_IDLE;
                end
            endcase
        end
    end

    // Status decode for the parent FSM.
    always_comb begin
        pulse_last = (step_r == STEP_PULSE) && (cnt_r == {CNT_W{1'b0}});
        done       = (step_r == STEP_HOLD);
    end

endmodule

// File: rtl/alu_sequencer.sv
// Host-side driver for the switch/button ALU. Accepts one {A, B, op}
// command, replays it as three switch+button load phases, waits for the
// ALU to settle, then returns the captured result over a valid/ready pair.
// Illegal opcodes skip the ALU entirely and return a flagged zero result.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int BUS_SIZE      = DEF_BUS_SIZE,
    parameter int OP_SIZE       = DEF_OP_SIZE,
    parameter int PULSE_CYCLES  = 2,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [BUS_SIZE-1:0] i_cmd_a,
    input  logic [BUS_SIZE-1:0] i_cmd_b,
    input  logic [OP_SIZE-1:0]  i_cmd_op,
    output logic [BUS_SIZE-1:0] o_swiches,
    output logic                o_boton1,
    output logic                o_boton2,
    output logic                o_boton3,
    input  logic [BUS_SIZE-1:0] i_ALUout,
    input  logic                i_carry,
    output logic                o_result_valid,
    input  logic                i_result_ready,
    output logic [BUS_SIZE-1:0] o_result,
    output logic                o_result_carry,
    output logic                o_illegal
);

    localparam int CNT_MAX = (PULSE_CYCLES > SETTLE_CYCLES) ? PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_SETUP_A  = 4'd1;
    localparam logic [3:0] ST_PULSE_A  = 4'd2;
    localparam logic [3:0] ST_HOLD_A   = 4'd3;
    localparam logic [3:0] ST_SETUP_B  = 4'd4;
    localparam logic [3:0] ST_PULSE_B  = 4'd5;
    localparam logic [3:0] ST_HOLD_B   = 4'd6;
    localparam logic [3:0] ST_SETUP_OP = 4'd7;
    localparam logic [3:0] ST_PULSE_OP = 4'd8;
    localparam logic [3:0] ST_HOLD_OP  = 4'd9;
    localparam logic [3:0] ST_SETTLE   = 4'd10;
    localparam logic [3:0] ST_DONE     = 4'd11;

    logic [3:0]          state_r;
    logic [3:0]          next_state_s;
    logic                accept_s;
    logic                legal_s;
    logic                strobe_start_s;
    logic                strobe_pulse_last_s;
    logic                strobe_done_s;
    logic                settle_last_s;
    logic [CNT_W-1:0]    settle_cnt_r;
    logic [BUS_SIZE-1:0] a_r;
    logic [BUS_SIZE-1:0] b_r;
    logic [OP_SIZE-1:0]  op_r;

    alu_strobe #(
        .PULSE_CYCLES (PULSE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_strobe (
        .clk        (i_clock),
        .rst        (i_reset),
        .start      (strobe_start_s),
        .pulse_last (strobe_pulse_last_s),
        .done       (strobe_done_s)
    );

    // Handshake qualification and opcode check.
    always_comb begin
        accept_s      = i_cmd_valid && o_cmd_ready;
        legal_s       = is_legal_op(i_cmd_op);
        settle_last_s = (settle_cnt_r == {CNT_W{1'b0}});
    end

    // Next-state logic; phase starts are issued to the strobe engine here.
    always_comb begin
        next_state_s   = state_r;
        strobe_start_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (legal_s) begin
                        next_state_s   = ST_SETUP_A;
                        strobe_start_s = 1'b1;
                    end else begin
                        next_state_s = ST_DONE;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_SETUP_A:  next_state_s = ST_PULSE_A;
            ST_PULSE_A:  next_state_s = strobe_pulse_last_s ? ST_HOLD_A : ST_PULSE_A;
            ST_HOLD_A: begin
                if (strobe_done_s) begin
                    next_state_s   = ST_SETUP_B;
                    strobe_start_s = 1'b1;
                end else begin
                    next_state_s = ST_HOLD_A;
                end
            end
            ST_SETUP_B:  next_state_s = ST_PULSE_B;
            ST_PULSE_B:  next_state_s = strobe_pulse_last_s ? ST_HOLD_B : ST_PULSE_B;
            ST_HOLD_B: begin
                if (strobe_done_s) begin
                    next_state_s   = ST_SETUP_OP;
                    strobe_start_s = 1'b1;
                end else begin
                    next_state_s = ST_HOLD_B;
                end
            end
            ST_SETUP_OP: next_state_s = ST_PULSE_OP;
            ST_PULSE_OP: next_state_s = strobe_pulse_last_s ? ST_HOLD_OP : ST_PULSE_OP;
            ST_HOLD_OP:  next_state_s = strobe_done_s ? ST_SETTLE : ST_HOLD_OP;
            ST_SETTLE:   next_state_s = settle_last_s ? ST_DONE : ST_SETTLE;
            ST_DONE:     next_state_s = i_result_ready ? ST_IDLE : ST_DONE;
            default:     next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Command capture at the accepting edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            a_r  <= {BUS_SIZE{1'b0}};
            b_r  <= {BUS_SIZE{1'b0}};
            op_r <= {OP_SIZE{1'b0}};
        end else if (accept_s) begin
            a_r  <= i_cmd_a;
            b_r  <= i_cmd_b;
            op_r <= i_cmd_op;
        end
    end

    // Settle counter: reloads on SETTLE entry, counts down to the capture edge.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            settle_cnt_r <= {CNT_W{1'b0}};
        end else if ((next_state_s == ST_SETTLE) && (state_r != ST_SETTLE)) begin
            settle_cnt_r <= CNT_W'(SETTLE_CYCLES - 1);
        end else if ((state_r == ST_SETTLE) && !settle_last_s) begin
            settle_cnt_r <= settle_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Handshake and button outputs registered from the next state so they
    // line up with the state they belong to; reset clears them at once.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_cmd_ready    <= 1'b1;
            o_result_valid <= 1'b0;
            o_boton1       <= 1'b0;
            o_boton2       <= 1'b0;
            o_boton3       <= 1'b0;
        end else begin
            o_cmd_ready    <= (next_state_s == ST_IDLE);
            o_result_valid <= (next_state_s == ST_DONE);
            o_boton1       <= (next_state_s == ST_PULSE_A);
            o_boton2       <= (next_state_s == ST_PULSE_B);
            o_boton3       <= (next_state_s == ST_PULSE_OP);
        end
    end

    // Switch bus: operand for the upcoming phase. On the accepting edge the
    // operand register is not yet loaded, so A comes straight from the port.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_swiches <= {BUS_SIZE{1'b0}};
        end else begin
            case (next_state_s)
                ST_SETUP_A, ST_PULSE_A, ST_HOLD_A:
                    o_swiches <= (state_r == ST_IDLE) ? i_cmd_a : a_r;
                ST_SETUP_B, ST_PULSE_B, ST_HOLD_B:
                    o_swiches <= b_r;
                ST_SETUP_OP, ST_PULSE_OP, ST_HOLD_OP:
                    o_swiches <= BUS_SIZE'(op_r);
                default:
                    o_swiches <= {BUS_SIZE{1'b0}};
            endcase
        end
    end

    // Result capture: cleared on accept, loaded from the ALU on the last
    // settle edge, and otherwise held so it is stable under backpressure.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_result       <= {BUS_SIZE{1'b0}};
            o_result_carry <= 1'b0;
            o_illegal      <= 1'b0;
        end else if (accept_s) begin
            o_result       <= {BUS_SIZE{1'b0}};
            o_result_carry <= 1'b0;
            o_illegal      <= !legal_s;
        end else if ((state_r == ST_SETTLE) && settle_last_s) begin
            o_result       <= i_ALUout;
            o_result_carry <= i_carry;
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural switch/button ALU.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic       clk;
    logic       i_reset;
    logic       i_cmd_valid;
    logic       o_cmd_ready;
    logic [7:0] i_cmd_a;
    logic [7:0] i_cmd_b;
    logic [5:0] i_cmd_op;
    logic [7:0] o_swiches;
    logic       o_boton1;
    logic       o_boton2;
    logic       o_boton3;
    logic [7:0] alu_out;
    logic       alu_carry;
    logic       o_result_valid;
    logic       i_result_ready;
    logic [7:0] o_result;
    logic       o_result_carry;
    logic       o_illegal;

    int tests_run;
    int tests_failed;

    alu_sequencer dut (
        .i_clock        (clk),
        .i_reset        (i_reset),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_a        (i_cmd_a),
        .i_cmd_b        (i_cmd_b),
        .i_cmd_op       (i_cmd_op),
        .o_swiches      (o_swiches),
        .o_boton1       (o_boton1),
        .o_boton2       (o_boton2),
        .o_boton3       (o_boton3),
        .i_ALUout       (alu_out),
        .i_carry        (alu_carry),
        .o_result_valid (o_result_valid),
        .i_result_ready (i_result_ready),
        .o_result       (o_result),
        .o_result_carry (o_result_carry),
        .o_illegal      (o_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: buttons latch the switches into A, B and opcode.
    logic [7:0] alu_a, alu_b;
    logic [5:0] alu_op;
    always @(posedge clk) begin
        if (o_boton1) alu_a  <= o_swiches;
        if (o_boton2) alu_b  <= o_swiches;
        if (o_boton3) alu_op <= o_swiches[5:0];
    end
    always_comb begin
        logic [8:0] wide;
        wide = 9'd0;
        case (alu_op)
            OP_ADD: wide = {1'b0, alu_a} + {1'b0, alu_b};
            OP_SUB: wide = {1'b0, alu_a} - {1'b0, alu_b};
            OP_AND: wide = {1'b0, alu_a & alu_b};
            OP_OR:  wide = {1'b0, alu_a | alu_b};
            OP_XOR: wide = {1'b0, alu_a ^ alu_b};
            OP_NOR: wide = {1'b0, ~(alu_a | alu_b)};
            OP_SRL: wide = {1'b0, alu_a >> alu_b};
            OP_SRA: wide = {1'b0, 8'($signed(alu_a) >>> alu_b)};
            default: wide = 9'd0;
        endcase
        alu_out   = wide[7:0];
        alu_carry = wide[8];
    end

    // Present one command and return just after its accepting edge.
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_a = a;
        i_cmd_b = b;
        i_cmd_op = op;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b0;
    endtask

    // Observe cycles k+1.. until o_result_valid (bounded); optionally pulse
    // a spurious command in cycle inj.
    task automatic watch(input int inj, output int vcyc, output int c1, output int c2,
                         output int c3, output int ovl, output int rdy_hi, output int b1_first,
                         output logic [7:0] sw1, output logic [7:0] sw5, output logic [7:0] sw9);
        vcyc = 0; c1 = 0; c2 = 0; c3 = 0; ovl = 0; rdy_hi = 0; b1_first = 0;
        sw1 = 8'h00; sw5 = 8'h00; sw9 = 8'h00;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (o_boton1) begin
                c1++;
                if (b1_first == 0) b1_first = n;
            end
            if (o_boton2) c2++;
            if (o_boton3) c3++;
            if (int'(o_boton1) + int'(o_boton2) + int'(o_boton3) > 1) ovl++;
            if (o_cmd_ready) rdy_hi++;
            if (n == 1) sw1 = o_swiches;
            if (n == 5) sw5 = o_swiches;
            if (n == 9) sw9 = o_swiches;
            if (n == inj) begin
                i_cmd_valid = 1'b1;
                i_cmd_a = 8'h11;
                i_cmd_b = 8'h22;
                i_cmd_op = OP_ADD;
            end else if (n == inj + 1) begin
                i_cmd_valid = 1'b0;
            end
            if (o_result_valid) begin
                vcyc = n;
                break;
            end
        end
        i_cmd_valid = 1'b0;
    endtask

    task automatic consume();
        i_result_ready = 1'b1;
        @(posedge clk);
        #1;
        i_result_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({o_cmd_ready, o_boton1, o_boton2, o_boton3, o_result_valid, o_result_carry, o_illegal} !== 7'b1000000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 1000000",
                     {o_cmd_ready, o_boton1, o_boton2, o_boton3, o_result_valid, o_result_carry, o_illegal});
        end
        tests_run++;
        if ({o_swiches, o_result} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_data: got %h expected 0000", {o_swiches, o_result});
        end
        i_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add();
        int v, c1, c2, c3, ovl, rdy, bf;
        logic [7:0] s1, s5, s9;
        issue(8'd255, 8'd2, OP_ADD);
        watch(0, v, c1, c2, c3, ovl, rdy, bf, s1, s5, s9);
        tests_run++;
        if (v !== 15) begin tests_failed++; $display("FAIL add_latency: got %0d expected 15", v); end
        tests_run++;
        if ({c1, c2, c3} !== {32'd2, 32'd2, 32'd2}) begin
            tests_failed++; $display("FAIL add_pulse_len: got %0d %0d %0d expected 2 2 2", c1, c2, c3);
        end
        tests_run++;
        if (ovl !== 0) begin tests_failed++; $display("FAIL add_overlap: got %0d expected 0", ovl); end
        tests_run++;
        if (bf !== 2) begin tests_failed++; $display("FAIL add_b1_first: got %0d expected 2", bf); end
        tests_run++;
        if ({o_result_carry, o_result} !== 9'h101) begin
            tests_failed++; $display("FAIL add_result: got %h expected 101", {o_result_carry, o_result});
        end
        consume();
    endtask

    task automatic test_sub();
        int v, c1, c2, c3, ovl, rdy, bf;
        logic [7:0] s1, s5, s9;
        issue(8'd10, 8'd4, OP_SUB);
        watch(5, v, c1, c2, c3, ovl, rdy, bf, s1, s5, s9);
        tests_run++;
        if (rdy !== 0) begin tests_failed++; $display("FAIL sub_ready_low: got %0d expected 0", rdy); end
        tests_run++;
        if (v !== 15) begin tests_failed++; $display("FAIL sub_latency: got %0d expected 15", v); end
        tests_run++;
        if ({o_result_carry, o_result} !== 9'h006) begin
            tests_failed++; $display("FAIL sub_result: got %h expected 006", {o_result_carry, o_result});
        end
        consume();
        repeat (3) @(negedge clk);
        tests_run++;
        if ({o_cmd_ready, o_result_valid, o_boton1} !== 3'b100) begin
            tests_failed++; $display("FAIL sub_no_ghost: got %b expected 100", {o_cmd_ready, o_result_valid, o_boton1});
        end
    endtask

    task automatic test_and_switches();
        int v, c1, c2, c3, ovl, rdy, bf;
        logic [7:0] s1, s5, s9;
        issue(8'h37, 8'h65, OP_AND);
        watch(0, v, c1, c2, c3, ovl, rdy, bf, s1, s5, s9);
        tests_run++;
        if ({s1, s5, s9} !== 24'h376524) begin
            tests_failed++; $display("FAIL and_switches: got %h expected 376524", {s1, s5, s9});
        end
        tests_run++;
        if (o_result !== 8'h25) begin tests_failed++; $display("FAIL and_result: got %h expected 25", o_result); end
        tests_run++;
        if (o_swiches !== 8'h00) begin tests_failed++; $display("FAIL done_switches: got %h expected 00", o_swiches); end
        consume();
    endtask

    task automatic test_illegal();
        int v, c1, c2, c3, ovl, rdy, bf;
        logic [7:0] s1, s5, s9;
        issue(8'h12, 8'h34, 6'b111111);
        watch(0, v, c1, c2, c3, ovl, rdy, bf, s1, s5, s9);
        tests_run++;
        if (v !== 1) begin tests_failed++; $display("FAIL ill_latency: got %0d expected 1", v); end
        tests_run++;
        if ({o_illegal, o_result_carry, o_result} !== 10'h200) begin
            tests_failed++; $display("FAIL ill_result: got %h expected 200", {o_illegal, o_result_carry, o_result});
        end
        tests_run++;
        if (c1 + c2 + c3 !== 0) begin tests_failed++; $display("FAIL ill_buttons: got %0d expected 0", c1 + c2 + c3); end
        consume();
        issue(8'h80, 8'h03, OP_SRL);
        @(negedge clk);
        tests_run++;
        if (o_illegal !== 1'b0) begin tests_failed++; $display("FAIL ill_clear: got %b expected 0", o_illegal); end
        watch(0, v, c1, c2, c3, ovl, rdy, bf, s1, s5, s9);
        tests_run++;
        if (o_result !== 8'h10) begin tests_failed++; $display("FAIL srl_result: got %h expected 10", o_result); end
        consume();
    endtask

    task automatic test_backpressure();
        int v, c1, c2, c3, ovl, rdy, bf, bad;
        logic [7:0] s1, s5, s9;
        issue(8'hF0, 8'h0F, OP_OR);
        watch(0, v, c1, c2, c3, ovl, rdy, bf, s1, s5, s9);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_result !== 8'hFF || o_result_valid !== 1'b1 || o_cmd_ready !== 1'b0 || o_illegal !== 1'b0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL bp_stable: got %0d bad cycles expected 0", bad); end
        consume();
        @(negedge clk);
        tests_run++;
        if ({o_cmd_ready, o_result_valid} !== 2'b10) begin
            tests_failed++; $display("FAIL bp_release: got %b expected 10", {o_cmd_ready, o_result_valid});
        end
    endtask

    task automatic test_reset_mid_pulse();
        int v, c1, c2, c3, ovl, rdy, bf;
        logic [7:0] s1, s5, s9;
        issue(8'h01, 8'h02, OP_ADD);
        repeat (6) @(negedge clk);
        tests_run++;
        if (o_boton2 !== 1'b1) begin tests_failed++; $display("FAIL rst_in_pulse_b: got %b expected 1", o_boton2); end
        i_reset = 1'b1;
        #1;
        tests_run++;
        if ({o_boton1, o_boton2, o_boton3, o_swiches, o_cmd_ready, o_result_valid} !== 13'b0000000000010) begin
            tests_failed++;
            $display("FAIL rst_async: got %b expected 0000000000010",
                     {o_boton1, o_boton2, o_boton3, o_swiches, o_cmd_ready, o_result_valid});
        end
        @(negedge clk);
        i_reset = 1'b0;
        issue(8'hAA, 8'hFF, OP_XOR);
        watch(0, v, c1, c2, c3, ovl, rdy, bf, s1, s5, s9);
        tests_run++;
        if (o_result !== 8'h55) begin tests_failed++; $display("FAIL xor_result: got %h expected 55", o_result); end
        consume();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        i_reset = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_a = 8'h00;
        i_cmd_b = 8'h00;
        i_cmd_op = 6'b000000;
        i_result_ready = 1'b0;
        #2;
        test_reset();
        test_add();
        test_sub();
        test_and_switches();
        test_illegal();
        test_backpressure();
        test_reset_mid_pulse();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
